exp_kernal_buffer_ctrl: RTL and testbench

Parametrised kernel buffer controller for the expand stage: it accepts packed kernel words over a valid/ready write port and width-converts them into an internal kernel RAM. It then replays the stored kernel set, one depth-slice group per request, for a configurable number of output pixels. It sits between the kernel DMA/FIFO path and the expand MAC array, and generalises the fixed 64→32-bit expand-1x1 kernel path to arbitrary width ratio, RAM depth and replay count. It adds a write handshake, a read valid tag and a completion pulse.

---
 rtl/exp_kernal_pkg.sv | 16 +
 rtl/exp_kernal_buf_ram.sv | 19 +
 rtl/exp_kernal_buffer_ctrl.sv | 132 +++++++++++++
 tb/tb_exp_kernal_buffer_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_kernal_pkg.sv
// exp_kernal_pkg: FSM encoding and width-ratio helpers shared by the kernel buffer controller
package exp_kernal_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, STREAM, DONE} state_e;
  function automatic int ratio(input int wr_w, input int rd_w);
    return wr_w / rd_w;
  endfunction
  function automatic int log2r(input int r);
    int n = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < r) n = i + 1;
    return n;
  endfunction
  function automatic bit ratio_ok(input int wr_w, input int rd_w);
    int r = wr_w / rd_w;
    return rd_w > 0 && r >= 1 && wr_w == r * rd_w && (r & (r - 1)) == 0;
  endfunction
endpackage

// File: rtl/exp_kernal_buf_ram.sv
// exp_kernal_buf_ram: simple dual-port kernel RAM with one write port and a registered read port
module exp_kernal_buf_ram #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/exp_kernal_buffer_ctrl.sv
// exp_kernal_buffer_ctrl: width-converting kernel RAM loader and per-group replay streamer
module exp_kernal_buffer_ctrl
  import exp_kernal_pkg::*;
#(
  parameter int WR_W    = 64,
  parameter int RD_W    = 32,
  parameter int ADDR_W  = 12,
  parameter int DEPTH_W = 6,
  parameter int REP_W   = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               en_i,
  input  logic [ADDR_W-1:0]  cfg_tot_words_m1_i,
  input  logic [ADDR_W-1:0]  cfg_grp_words_i,
  input  logic [DEPTH_W-1:0] cfg_depth_m1_i,
  input  logic [REP_W-1:0]   cfg_replay_m1_i,
  input  logic [WR_W-1:0]    wr_data_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic               rd_req_i,
  output logic               rd_ready_o,
  output logic [RD_W-1:0]    rd_data_o,
  output logic               rd_valid_o,
  output logic [DEPTH_W:0]   grp_ready_cnt_o,
  output logic               busy_o,
  output logic               done_o
);
  localparam int R  = ratio(WR_W, RD_W);
  localparam int LR = log2r(R);
  localparam int SW = LR > 0 ? LR : 1;
  if (!ratio_ok(WR_W, RD_W)) begin : g_bad_ratio
    $error("WR_W must be RD_W times a power of two");
  end
  state_e state_q, state_d;
  logic [ADDR_W-1:0] tot_q, tot_d, gw_q, gw_d, wr_addr_q, wr_addr_d, wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] base_q, base_d, cnt_q, cnt_d;
  logic [DEPTH_W-1:0] dep_q, dep_d, grp_idx_q, grp_idx_d, nxt_idx;
  logic [REP_W-1:0] rep_m1_q, rep_m1_d, rep_q, rep_d;
  logic [DEPTH_W:0] grp_cnt_q, grp_cnt_d, grp_max;
  logic [WR_W-1:0] data_q, data_d;
  logic [SW-1:0] slice_q, slice_d;
  logic pend_q, pend_d, full_q, full_d, rd_valid_q, rd_valid_d, done_q, done_d;
  logic restart, wr_acc, rd_acc, last_wr, last_slice, grp_full, grp_end, last_grp, sess_end;
  logic [RD_W-1:0] ram_q;
  assign restart    = start_i & en_i;
  assign last_slice = slice_q == SW'(R - 1);
  assign last_wr    = pend_q & (wr_addr_q == tot_q);
  assign grp_full   = (wcnt_q == gw_q - 1'b1) | last_wr;
  assign grp_max    = {1'b0, dep_q} + 1'b1;
  assign grp_end    = cnt_q == gw_q - 1'b1;
  assign last_grp   = grp_idx_q == dep_q;
  assign sess_end   = last_grp & (rep_q == rep_m1_q);
  assign nxt_idx    = last_grp ? '0 : grp_idx_q + 1'b1;
  assign wr_acc     = wr_valid_i & wr_ready_o;
  assign rd_acc     = rd_req_i & rd_ready_o;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      {tot_q, gw_q, wr_addr_q, wcnt_q, base_q, cnt_q} <= '0;
      {dep_q, grp_idx_q, rep_m1_q, rep_q, grp_cnt_q} <= '0;
      {data_q, slice_q, pend_q, full_q, rd_valid_q, done_q} <= '0;
    end else begin
      state_q <= state_d;
      {tot_q, gw_q, wr_addr_q, wcnt_q, base_q, cnt_q} <= {tot_d, gw_d, wr_addr_d, wcnt_d, base_d, cnt_d};
      {dep_q, grp_idx_q, rep_m1_q, rep_q, grp_cnt_q} <= {dep_d, grp_idx_d, rep_m1_d, rep_d, grp_cnt_d};
      {data_q, slice_q, pend_q, full_q, rd_valid_q, done_q} <= {data_d, slice_d, pend_d, full_d, rd_valid_d, done_d};
    end
  end
  // a request on the last address of a group chains straight into the next group
  always_comb begin
    state_d = restart ? ARMED :
              (state_q == ARMED && rd_acc) ? STREAM :
              (state_q == STREAM && grp_end) ? (sess_end ? DONE : rd_acc ? STREAM : ARMED) :
              (state_q == DONE) ? IDLE : state_q;
  end
  always_comb begin
    busy_o     = state_q != IDLE;
    wr_ready_o = busy_o && !full_q && !(pend_q && !last_slice) && !last_wr;
    rd_ready_o = (state_q == ARMED && grp_cnt_q > {1'b0, grp_idx_q}) ||
                 (state_q == STREAM && grp_end && !sess_end && grp_cnt_q > {1'b0, nxt_idx});
    rd_valid_d = state_q == STREAM;
    done_d     = state_q == DONE && !restart;
  end
  always_comb begin
    {tot_d, gw_d, wr_addr_d, wcnt_d, base_d, cnt_d} = {tot_q, gw_q, wr_addr_q, wcnt_q, base_q, cnt_q};
    {dep_d, grp_idx_d, rep_m1_d, rep_d, grp_cnt_d} = {dep_q, grp_idx_q, rep_m1_q, rep_q, grp_cnt_q};
    {data_d, slice_d, pend_d, full_d} = {data_q, slice_q, pend_q, full_q};
    if (pend_q) begin
      data_d    = data_q >> RD_W;
      wr_addr_d = wr_addr_q + 1'b1;
      slice_d   = slice_q + 1'b1;
      pend_d    = !(last_wr || last_slice);
      full_d    = last_wr;
      wcnt_d    = grp_full ? '0 : wcnt_q + 1'b1;
      grp_cnt_d = (grp_full && grp_cnt_q != grp_max) ? grp_cnt_q + 1'b1 : grp_cnt_q;
    end
    if (wr_acc) begin
      data_d  = wr_data_i;
      slice_d = '0;
      pend_d  = 1'b1;
    end
    if (state_q == STREAM) begin
      cnt_d     = grp_end ? '0 : cnt_q + 1'b1;
      base_d    = !grp_end ? base_q : last_grp ? '0 : base_q + gw_q;
      grp_idx_d = grp_end ? nxt_idx : grp_idx_q;
      rep_d     = (grp_end && last_grp) ? rep_q + 1'b1 : rep_q;
    end
    if (restart) begin
      tot_d    = cfg_tot_words_m1_i;
      gw_d     = (cfg_grp_words_i == '0) ? ADDR_W'(1) : cfg_grp_words_i;
      dep_d    = cfg_depth_m1_i;
      rep_m1_d = cfg_replay_m1_i;
      {wr_addr_d, wcnt_d, base_d, cnt_d, grp_idx_d, rep_d, grp_cnt_d} = '0;
      {slice_d, pend_d, full_d} = '0;
    end
  end
  exp_kernal_buf_ram #(.AW(ADDR_W), .DW(RD_W)) u_ram (
    .clk_i   (clk_i),
    .we_i    (pend_q),
    .waddr_i (wr_addr_q),
    .wdata_i (data_q[RD_W-1:0]),
    .re_i    (state_q == STREAM),
    .raddr_i (base_q + cnt_q),
    .rdata_o (ram_q)
  );
  assign rd_valid_o      = rd_valid_q;
  assign rd_data_o       = rd_valid_q ? ram_q : '0;
  assign done_o          = done_q;
  assign grp_ready_cnt_o = grp_cnt_q;
endmodule

// File: tb/tb_exp_kernal_buffer_ctrl.sv
// tb_exp_kernal_buffer_ctrl: directed scenarios for the kernel buffer controller at R=2
module tb_exp_kernal_buffer_ctrl;
  logic clk_i = 0, rst_i = 1, start_i = 0, en_i = 1;
  logic [11:0] cfg_tot_words_m1_i = 0, cfg_grp_words_i = 0;
  logic [5:0] cfg_depth_m1_i = 0;
  logic [6:0] cfg_replay_m1_i = 0;
  logic [63:0] wr_data_i = 0;
  logic wr_valid_i = 0, rd_req_i = 0;
  logic wr_ready_o, rd_ready_o, rd_valid_o, busy_o, done_o;
  logic [31:0] rd_data_o;
  logic [6:0] grp_ready_cnt_o;
  int total = 0, passed = 0, cyc_n = 0, done_cnt = 0, run = 0, max_run = 0;
  int last_valid_cyc = 0, done_cyc = 0;
  logic [31:0] got[$];

  exp_kernal_buffer_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .en_i(en_i),
    .cfg_tot_words_m1_i(cfg_tot_words_m1_i), .cfg_grp_words_i(cfg_grp_words_i),
    .cfg_depth_m1_i(cfg_depth_m1_i), .cfg_replay_m1_i(cfg_replay_m1_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_req_i(rd_req_i), .rd_ready_o(rd_ready_o), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .grp_ready_cnt_o(grp_ready_cnt_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_n++;
  always @(negedge clk_i) begin
    if (rd_valid_o) begin
      got.push_back(rd_data_o);
      last_valid_cyc = cyc_n;
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    done_cnt = 0;
    max_run = 0;
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 32'h0;
  endfunction

  task automatic do_start(input logic [11:0] tot, input logic [11:0] gw, input logic [5:0] dep, input logic [6:0] rep);
    cfg_tot_words_m1_i = tot;
    cfg_grp_words_i = gw;
    cfg_depth_m1_i = dep;
    cfg_replay_m1_i = rep;
    start_i = 1;
    cyc(1);
    start_i = 0;
  endtask

  task automatic write_words(input logic [31:0] seed, input int n);
    for (int w = 0; w < n; w++) begin
      int k = 0;
      logic [31:0] lo;
      lo = seed + 32'(2 * w);
      wr_data_i = {lo + 32'd1, lo};
      wr_valid_i = 1;
      while (!wr_ready_o && k < 20) begin
        cyc(1);
        k++;
      end
      if (!wr_ready_o) begin
        total++;
        $display("FAIL wr_wait: wr_ready_o=%0b required 1", wr_ready_o);
      end
      cyc(1);
      wr_valid_i = 0;
    end
  endtask

  task automatic req_group();
    int k = 0;
    while (!rd_ready_o && k < 50) begin
      cyc(1);
      k++;
    end
    if (!rd_ready_o) begin
      total++;
      $display("FAIL req_wait: rd_ready_o=%0b required 1", rd_ready_o);
    end
    rd_req_i = 1;
    cyc(1);
    rd_req_i = 0;
  endtask

  task automatic test_reset();
    cyc(3);
    total++; if ({busy_o, wr_ready_o, rd_ready_o, rd_valid_o, done_o} !== 5'b0) $display("FAIL reset_ctl: got %b want 00000", {busy_o, wr_ready_o, rd_ready_o, rd_valid_o, done_o}); else passed++;
    total++; if (grp_ready_cnt_o !== 7'd0 || rd_data_o !== 32'd0) $display("FAIL reset_data: grp=%0d data=%h want 0 0", grp_ready_cnt_o, rd_data_o); else passed++;
    rst_i = 0;
    cyc(2);
    en_i = 0;
    do_start(12'd7, 12'd4, 6'd1, 7'd0);
    total++; if (busy_o !== 1'b0) $display("FAIL start_disabled: busy=%0b want 0", busy_o); else passed++;
    en_i = 1;
  endtask

  task automatic test_basic();
    int ready_seen = 0;
    do_start(12'd7, 12'd4, 6'd1, 7'd0);
    total++; if (busy_o !== 1'b1) $display("FAIL basic_busy: busy=%0b want 1", busy_o); else passed++;
    clear_mon();
    write_words(32'h1000_0000, 4);
    cyc(3);
    total++; if (grp_ready_cnt_o !== 7'd2) $display("FAIL basic_grp: got %0d want 2", grp_ready_cnt_o); else passed++;
    wr_data_i = 64'hDEAD_BEEF_0BAD_F00D;
    wr_valid_i = 1;
    repeat (4) begin
      if (wr_ready_o) ready_seen++;
      cyc(1);
    end
    wr_valid_i = 0;
    total++; if (ready_seen != 0) $display("FAIL basic_full: ready cycles %0d want 0", ready_seen); else passed++;
    req_group();
    req_group();
    cyc(8);
    total++; if (got.size() != 8) $display("FAIL basic_len: got %0d want 8", got.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (got_at(i) !== 32'h1000_0000 + 32'(i)) $display("FAIL basic_data[%0d]: got %h want %h", i, got_at(i), 32'h1000_0000 + 32'(i)); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt); else passed++;
    total++; if (done_cyc != last_valid_cyc + 1) $display("FAIL basic_done_time: got cycle %0d want %0d", done_cyc, last_valid_cyc + 1); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL basic_idle: busy=%0b want 0", busy_o); else passed++;
  endtask

  task automatic test_early_req();
    do_start(12'd3, 12'd4, 6'd0, 7'd0);
    clear_mon();
    rd_req_i = 1;
    cyc(1);
    rd_req_i = 0;
    cyc(4);
    total++; if (got.size() != 0) $display("FAIL early_drop: got %0d words want 0", got.size()); else passed++;
    write_words(32'h2000_0000, 1);
    cyc(3);
    total++; if (grp_ready_cnt_o !== 7'd0 || rd_ready_o !== 1'b0) $display("FAIL early_partial: grp=%0d ready=%0b want 0 0", grp_ready_cnt_o, rd_ready_o); else passed++;
    write_words(32'h2000_0002, 1);
    cyc(3);
    total++; if (grp_ready_cnt_o !== 7'd1 || rd_ready_o !== 1'b1) $display("FAIL early_ready: grp=%0d ready=%0b want 1 1", grp_ready_cnt_o, rd_ready_o); else passed++;
    total++; if (got.size() != 0) $display("FAIL early_quiet: got %0d words want 0", got.size()); else passed++;
    req_group();
    cyc(6);
    total++; if (got.size() != 4) $display("FAIL early_len: got %0d want 4", got.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (got_at(i) !== 32'h2000_0000 + 32'(i)) $display("FAIL early_data[%0d]: got %h want %h", i, got_at(i), 32'h2000_0000 + 32'(i)); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL early_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_replay();
    do_start(12'd7, 12'd4, 6'd1, 7'd2);
    clear_mon();
    write_words(32'h3000_0000, 4);
    cyc(3);
    repeat (5) req_group();
    cyc(6);
    total++; if (done_cnt != 0 || got.size() != 20) $display("FAIL replay_mid: done=%0d len=%0d want 0 20", done_cnt, got.size()); else passed++;
    req_group();
    cyc(7);
    total++; if (done_cnt != 1) $display("FAIL replay_done: got %0d want 1", done_cnt); else passed++;
    total++; if (got.size() != 24) $display("FAIL replay_len: got %0d want 24", got.size()); else passed++;
    for (int i = 0; i < 24; i++) begin
      total++; if (got_at(i) !== 32'h3000_0000 + 32'(i % 8)) $display("FAIL replay_data[%0d]: got %h want %h", i, got_at(i), 32'h3000_0000 + 32'(i % 8)); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    do_start(12'd5, 12'd3, 6'd1, 7'd0);
    write_words(32'h4000_0000, 3);
    cyc(3);
    clear_mon();
    req_group();
    req_group();
    cyc(6);
    total++; if (max_run != 6) $display("FAIL b2b_run: got %0d consecutive want 6", max_run); else passed++;
    total++; if (got.size() != 6) $display("FAIL b2b_len: got %0d want 6", got.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      total++; if (got_at(i) !== 32'h4000_0000 + 32'(i)) $display("FAIL b2b_data[%0d]: got %h want %h", i, got_at(i), 32'h4000_0000 + 32'(i)); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL b2b_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    do_start(12'd7, 12'd4, 6'd1, 7'd0);
    write_words(32'h5000_0000, 4);
    cyc(3);
    clear_mon();
    req_group();
    cyc(2);
    total++; if (rd_valid_o !== 1'b1) $display("FAIL rst_pre: rd_valid=%0b want 1", rd_valid_o); else passed++;
    #2 rst_i = 1;
    #1;
    total++; if ({busy_o, wr_ready_o, rd_ready_o, rd_valid_o, done_o} !== 5'b0) $display("FAIL rst_mid_ctl: got %b want 00000", {busy_o, wr_ready_o, rd_ready_o, rd_valid_o, done_o}); else passed++;
    total++; if (grp_ready_cnt_o !== 7'd0 || rd_data_o !== 32'd0) $display("FAIL rst_mid_data: grp=%0d data=%h want 0 0", grp_ready_cnt_o, rd_data_o); else passed++;
    cyc(1);
    rst_i = 0;
    cyc(1);
    do_start(12'd7, 12'd4, 6'd1, 7'd0);
    write_words(32'h5100_0000, 4);
    cyc(3);
    clear_mon();
    req_group();
    req_group();
    cyc(8);
    total++; if (got.size() != 8) $display("FAIL rst_rerun_len: got %0d want 8", got.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (got_at(i) !== 32'h5100_0000 + 32'(i)) $display("FAIL rst_rerun_data[%0d]: got %h want %h", i, got_at(i), 32'h5100_0000 + 32'(i)); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL rst_rerun_done: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_restart();
    do_start(12'd7, 12'd4, 6'd1, 7'd0);
    write_words(32'h6000_0000, 2);
    cyc(3);
    total++; if (grp_ready_cnt_o !== 7'd1) $display("FAIL restart_pre: grp=%0d want 1", grp_ready_cnt_o); else passed++;
    do_start(12'd3, 12'd2, 6'd1, 7'd0);
    total++; if (grp_ready_cnt_o !== 7'd0 || busy_o !== 1'b1) $display("FAIL restart_clear: grp=%0d busy=%0b want 0 1", grp_ready_cnt_o, busy_o); else passed++;
    clear_mon();
    write_words(32'h6100_0000, 2);
    cyc(3);
    total++; if (grp_ready_cnt_o !== 7'd2) $display("FAIL restart_grp: grp=%0d want 2", grp_ready_cnt_o); else passed++;
    req_group();
    req_group();
    cyc(6);
    total++; if (got.size() != 4) $display("FAIL restart_len: got %0d want 4", got.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (got_at(i) !== 32'h6100_0000 + 32'(i)) $display("FAIL restart_data[%0d]: got %h want %h", i, got_at(i), 32'h6100_0000 + 32'(i)); else passed++;
    end
    total++; if (done_cnt != 1) $display("FAIL restart_done: got %0d want 1", done_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_req();
    test_replay();
    test_back_to_back();
    test_reset_mid();
    test_restart();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
